circuit_evaluator: RTL and testbench

Sequential test harness for evolved combinational circuits: the driving/observing end of a candidate's 5-input/1-output interface. On start it sweeps every input vector and lets the candidate settle. It then samples the candidate output over several cycles to detect oscillation, which matters because evolved netlists can contain combinational loops. It assembles the measured truth table, scores it against an expected table, and reports fitness to the evolution controller.

---
 rtl/circuit_eval_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 36 +++
 rtl/circuit_evaluator.sv | 177 +++++++++++++++++
 tb/tb_circuit_evaluator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/circuit_eval_pkg.sv
// ============================================================================
// Module  : circuit_eval_pkg
// Purpose : Shared types and sizing helpers for the evolved-circuit harness.
//           Holds the sweep state encoding and the width helpers that the
//           evaluator uses to size its vector and phase counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package circuit_eval_pkg;

    // Sweep control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Number of input vectors a candidate of the given input width exposes
    function automatic int NUM_VECTORS(input int in_width);
        return 1 << in_width;
    endfunction

    // Width of a counter that runs 0..max(a,b)-1 (never narrower than 1 bit)
    function automatic int CNT_WIDTH(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage : circuit_eval_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Purpose : Single-bit two-flop synchronizer for an asynchronous input.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset (flops clear to 0)
//           i_d   - asynchronous input bit
//           o_q   - synchronized output bit (2 clk latency)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/circuit_evaluator.sv
// ============================================================================
// Module  : circuit_evaluator
// Purpose : Drives every input vector into an evolved combinational candidate,
//           waits for it to settle, samples its output several times to catch
//           oscillation (combinational loops), records the measured truth
//           table and scores it against an expected table.
// Ports   : clk            - clock
//           rst_n          - asynchronous active-low reset
//           start          - run request, honoured only when idle
//           abort          - cancel a run in progress (wins over start)
//           expected       - target truth table, latched on start
//           dut_in         - registered vector driven to the candidate
//           dut_out        - candidate output (asynchronous)
//           busy           - run in progress
//           done           - one-cycle pulse, results valid
//           truth_table    - measured table (first sample per vector)
//           unstable_mask  - vectors whose samples disagreed
//           score          - stable vectors matching expected
//           unstable_count - number of unstable vectors
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module circuit_evaluator
    import circuit_eval_pkg::*;
#(
    parameter int IN_WIDTH       = 5,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_SAMPLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [(1 << IN_WIDTH)-1:0]   expected,
    output logic [IN_WIDTH-1:0]          dut_in,
    input  logic                         dut_out,
    output logic                         busy,
    output logic                         done,
    output logic [(1 << IN_WIDTH)-1:0]   truth_table,
    output logic [(1 << IN_WIDTH)-1:0]   unstable_mask,
    output logic [IN_WIDTH:0]            score,
    output logic [IN_WIDTH:0]            unstable_count
);

    localparam int NV = NUM_VECTORS(IN_WIDTH);
    localparam int CW = CNT_WIDTH(SETTLE_CYCLES, STABLE_SAMPLES);

    localparam logic [CW-1:0]       SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]       SAMPLE_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [CW-1:0]       CNT_ONE     = CW'(1);
    localparam logic [IN_WIDTH-1:0] VEC_LAST    = '1;
    localparam logic [IN_WIDTH-1:0] VEC_ONE     = IN_WIDTH'(1);
    localparam logic [IN_WIDTH:0]   RES_ONE     = (IN_WIDTH + 1)'(1);

    state_t              r_state;
    logic [IN_WIDTH-1:0] r_vec;        // current vector; also drives dut_in
    logic [CW-1:0]       r_cnt;        // phase counter within SETTLE / SAMPLE
    logic [NV-1:0]       r_expected;
    logic [NV-1:0]       r_truth;
    logic [NV-1:0]       r_unmask;
    logic [IN_WIDTH:0]   r_score;
    logic [IN_WIDTH:0]   r_uncount;
    logic                r_busy;
    logic                r_done;

    logic w_sync;
    logic w_first;
    logic w_mis;
    logic w_unst;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (dut_out),
        .o_q   (w_sync)
    );

    // On the first sample cycle the reference value is the live sample itself
    // (it is only being written into the table on this edge), so a single
    // sample per vector still yields a correct verdict.
    assign w_first = (r_cnt == '0) ? w_sync : r_truth[r_vec];
    assign w_mis   = (r_cnt != '0) && (w_sync != r_truth[r_vec]);
    assign w_unst  = r_unmask[r_vec] | w_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_vec      <= '0;
            r_cnt      <= '0;
            r_expected <= '0;
            r_truth    <= '0;
            r_unmask   <= '0;
            r_score    <= '0;
            r_uncount  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start && !abort) begin
                    r_expected <= expected;
                    r_truth    <= '0;
                    r_unmask   <= '0;
                    r_score    <= '0;
                    r_uncount  <= '0;
                    r_vec      <= '0;
                    r_cnt      <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= SETTLE;
                end
            end else if (abort) begin
                // Partial results are left in place but never flagged valid
                r_state <= IDLE;
                r_vec   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    SETTLE: begin
                        if (r_cnt == SETTLE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= SAMPLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    SAMPLE: begin
                        if (r_cnt == '0) begin
                            r_truth[r_vec] <= w_sync;
                        end
                        if (w_mis) begin
                            r_unmask[r_vec] <= 1'b1;
                        end
                        if (r_cnt == SAMPLE_LAST) begin
                            if (w_unst) begin
                                r_uncount <= r_uncount + RES_ONE;
                            end else if (w_first == r_expected[r_vec]) begin
                                r_score <= r_score + RES_ONE;
                            end
                            r_cnt <= '0;
                            // Terminal check precedes the increment, so the
                            // vector counter never wraps.
                            if (r_vec == VEC_LAST) begin
                                r_state <= FINISH;
                            end else begin
                                r_vec   <= r_vec + VEC_ONE;
                                r_state <= SETTLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    FINISH: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign dut_in         = r_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign truth_table    = r_truth;
    assign unstable_mask  = r_unmask;
    assign score          = r_score;
    assign unstable_count = r_uncount;

endmodule : circuit_evaluator

`default_nettype wire

// File: tb/tb_circuit_evaluator.sv
// ============================================================================
// Module  : tb_circuit_evaluator
// Purpose : Self-checking bench for circuit_evaluator. A behavioural candidate
//           (parity, constant 0, or parity with an oscillating vector 5) is
//           wired to dut_in/dut_out. Each accepted run pushes its expected
//           results into a scoreboard; a monitor pops and compares on done.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_circuit_evaluator;

    localparam int IW  = 5;
    localparam int NV  = 32;
    localparam int LAT = 193;

    localparam logic [31:0] PARITY_TT = 32'h96696996;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NV-1:0] expected = '0;
    logic [IW-1:0] dut_in;
    logic          dut_out;
    logic          busy;
    logic          done;
    logic [NV-1:0] truth_table;
    logic [NV-1:0] unstable_mask;
    logic [IW:0]   score;
    logic [IW:0]   unstable_count;

    int   mode = 0;      // 0: parity, 1: constant 0, 2: parity oscillating at v=5
    logic tog  = 1'b0;
    int   cyc  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [31:0] tt;
        logic [31:0] tt_care;
        logic [31:0] um;
        int          sc;
        int          uc;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    circuit_evaluator #(
        .IN_WIDTH       (IW),
        .SETTLE_CYCLES  (4),
        .STABLE_SAMPLES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .expected       (expected),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .truth_table    (truth_table),
        .unstable_mask  (unstable_mask),
        .score          (score),
        .unstable_count (unstable_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
    end

    // Behavioural candidate
    assign dut_out = (mode == 1) ? 1'b0
                   : ((^dut_in) ^ ((mode == 2) && (dut_in == 5'd5) && tog));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                check("done_latency", 64'(cyc), 64'(e.done_cyc));
                check("busy_at_done", 64'(busy), 64'd0);
                check("truth_table", 64'(truth_table & e.tt_care), 64'(e.tt & e.tt_care));
                check("unstable_mask", 64'(unstable_mask), 64'(e.um));
                check("score", 64'(score), 64'(e.sc));
                check("unstable_count", 64'(unstable_count), 64'(e.uc));
            end
        end
    end

    // Issue an accepted start (called on a negedge) and push the expectation
    task automatic launch(input logic [31:0] exp_tt, input exp_t e);
        expected = exp_tt;
        start    = 1'b1;
        e.done_cyc = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (!done && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [31:0] tt, input logic [31:0] care,
                                input logic [31:0] um, input int sc, input int uc);
        exp_t e;
        e.tt = tt; e.tt_care = care; e.um = um; e.sc = sc; e.uc = uc; e.done_cyc = 0;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        exp_t par;
        par = mk(PARITY_TT, 32'hFFFFFFFF, 32'h0, 32, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {27'd0, dut_in, busy, done, score, unstable_count},
              64'd0);
        check("reset_tables", {truth_table, unstable_mask}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: parity candidate, full score
        mode = 0;
        launch(PARITY_TT, par);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(LAT + 20);

        // 2: constant-0 candidate against all-ones; dut_in steps every 6 cycles
        mode = 1;
        launch(32'hFFFFFFFF, mk(32'h0, 32'hFFFFFFFF, 32'h0, 0, 0));
        bad = 0;
        for (int k = 0; k < 192; k++) begin
            if (dut_in !== IW'(k / 6)) bad++;
            @(negedge clk);
        end
        check("dut_in_steps", 64'(bad), 64'd0);
        wait_done(20);

        // 3: oscillating vector 5; its first sample is phase-dependent
        mode = 2;
        launch(PARITY_TT, mk(PARITY_TT, 32'hFFFFFFDF, 32'h00000020, 31, 1));
        wait_done(LAT + 20);

        // 4: abort 50 cycles into a run, then a clean run
        mode = 0;
        expected = PARITY_TT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("busy_before_abort", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("busy_after_abort", 64'(busy), 64'd0);
        check("dut_in_after_abort", 64'(dut_in), 64'd0);
        repeat (200) @(negedge clk);   // monitor flags any stray done
        launch(PARITY_TT, par);
        wait_done(LAT + 20);

        // Abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 64'(busy), 64'd0);

        // 5: extra start pulses during a run are ignored
        launch(PARITY_TT, par);
        repeat (9) @(negedge clk);
        expected = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (89) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expected = PARITY_TT;
        wait_done(LAT);

        // 6: asynchronous reset mid-SAMPLE (vector 2), then a normal run
        launch(PARITY_TT, par);
        repeat (16) @(negedge clk);
        check("pre_reset_dut_in", 64'(dut_in), 64'd2);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_outputs",
              {27'd0, dut_in, busy, done, score, unstable_count},
              64'd0);
        check("async_reset_tables", {truth_table, unstable_mask}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'd0);
        launch(PARITY_TT, par);
        wait_done(LAT + 20);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_circuit_evaluator

`default_nettype wire
